timestep_controller: RTL
========================

# timestep_controller

Instruction sequencer for the 10-bit processor, directly downstream of the 2-bit timestep counter. It consumes the counter value `T`, latches the instruction word, and drives per-timestep datapath enables. It also drives the counter's `CLR` to hold it at T0 while idle and to restart it after the last timestep of each instruction, and it keeps a retired-instruction count for performance measurement.

## Interface
- `NREG`, 4: number of general registers. Fixed; the `rx` and `ry` fields are 2 bits.
- `CNTW`, 8: width of the retired-instruction counter.

- `CLKb`  in  1  system clock. All state updates on the falling edge, the same edge the timestep counter uses.
- `CLRb`  in  1  reset, asynchronous, active-low.
- `EXEC`  in  1  start request, sampled while idle.
- `INSTR`  in  10  instruction word: `[9:6]` opcode, `[5:4]` rx, `[3:2]` ry, `[1:0]` unused.
- `T`  in  2  timestep from the counter.
- `CLR`  out  1  registered clear to the timestep counter.
- `IRin`  out  1  instruction-register load strobe, for the datapath view.
- `Rin`  out  4  one-hot register write enables.
- `Rout`  out  4  one-hot register bus drives.
- `ENW`  out  1  external data onto the bus.
- `Ain`  out  1  ALU A-operand latch.
- `Gin`  out  1  ALU result latch.
- `Gout`  out  1  ALU result onto the bus.
- `FN`  out  2  ALU function: 00 add, 01 sub, 10 and, 11 xor.
- `DONE`  out  1  current timestep is the last one of the instruction.
- `ERR`  out  1  sticky illegal-opcode flag.
- `ICNT`  out  `CNTW`  retired legal-instruction count.

## Operation
- A cycle is the interval between falling edges of `CLKb`.
- The block has two states, IDLE and RUN. Registered state is `busy`, `IR[9:0]`, `CLR`, `ERR` and `ICNT`.
- Reset values: `busy=0`, `IR=0`, `CLR=1`, `ERR=0`, `ICNT=0`. All combinational outputs are 0 because they are gated by `busy`.
- IDLE:
  - `CLR` stays 1, which holds the counter at 0.
  - On an edge where `EXEC=1`: `busy` goes to 1 and `CLR` goes to 0.
  - `EXEC` is ignored while RUN.
- RUN, `T=0`:
  - `IRin=1`.
  - `IR` captures `INSTR` at the edge ending the cycle.
  - No other outputs are asserted.
- RUN, `T>=1`: outputs decode from `IR` and `T`:
  - LD (0000): T1 `ENW`, `Rin[rx]`, `DONE`.
  - CP (0001): T1 `Rout[ry]`, `Rin[rx]`, `DONE`.
  - ADD (0010), SUB (0011), AND (0100), XOR (0101):
    - T1 `Rout[rx]`, `Ain`.
    - T2 `Rout[ry]`, `Gin`, `FN`=op.
    - T3 `Gout`, `Rin[rx]`, `DONE`.
    - `FN` is valid only at T2; otherwise 00.
  - Any other opcode: T1 `DONE` only, no enables.
- At the edge ending a `DONE` cycle:
  - `busy` goes to 0 and `CLR` goes to 1.
  - `ICNT` increments if the opcode was legal; it wraps from max to 0.
  - `ERR` goes to 1 if the opcode was illegal. `ERR` is cleared only by `CLRb`.
- A new instruction always passes through at least one IDLE cycle. Back-to-back issue requires `EXEC` high on that IDLE edge.
- `rx==ry` is legal. For CP the same bit is set in `Rin` and `Rout`.

## Timing
- Issue latency: `EXEC` sampled at edge n, T0 (`IRin`) is cycle n+1, T1 is cycle n+2.
- Instruction length, T0 through `DONE`: LD/CP/illegal 2 cycles, ALU ops 4 cycles.
- Issue-to-issue spacing is 3 cycles for LD/CP and 5 cycles for ALU ops.
- `CLR` is registered. After the `DONE` edge the counter may briefly show T+1 before the asynchronous clear. The block ignores `T` whenever `busy=0`.
- `T` is never 3 for a 2-step instruction, because `DONE` at T1 forces the clear.
- `CLRb` asserted mid-instruction:
  - All registered state returns to reset values immediately.
  - Outputs drop to 0 within the same cycle.
  - `ICNT` does not count the aborted instruction.
- `CLRb` release: first possible issue is the first falling edge with `CLRb=1` and `EXEC=1`.

## Test plan
- Reset: hold `CLRb=0` with `EXEC=1` → `CLR=1`, `ICNT=0`, `ERR=0`, all enables 0. Release with `EXEC=0` → `CLR` stays 1 and the counter stays at 0.
- LD: `INSTR=0000_10_00_00`, `EXEC` pulsed → T0 `IRin`, then T1 `ENW=1`, `Rin=0100`, `DONE=1`. Next cycle `CLR=1` and `ICNT=1`.
- ADD: `INSTR=0010_01_11_00` →
  - T1 `Rout=0010`, `Ain`.
  - T2 `Rout=1000`, `Gin`, `FN=00`.
  - T3 `Gout`, `Rin=0010`, `DONE`.
  - Repeat for SUB, AND and XOR, checking `FN` = 01, 10, 11.
- Illegal: `INSTR=1111_00_00_00` → T1 `DONE` only, all enables 0, `ERR=1` sticky across a following legal CP, `ICNT` unchanged.
- Back-to-back: `EXEC` held high over 3 LDs → issues spaced 3 cycles apart, `ICNT=3`. Then 256 further legal instructions → `ICNT` wraps to 3.
- Mid-reset: assert `CLRb` during T2 of SUB → outputs 0 at once, `ICNT` not incremented, next CP executes normally.

Source files
------------

// File: rtl/timestep_controller_if.sv
// Bundle between the timestep controller and its environment: start request,
// instruction word and counter value in; counter clear, datapath enables and status out.
interface timestep_controller_if #(
  parameter int NREG = 4,
  parameter int CNTW = 8
);
  logic            EXEC;
  logic [9:0]      INSTR;
  logic [1:0]      T;
  logic            CLR;
  logic            IRin;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic            ENW;
  logic            Ain;
  logic            Gin;
  logic            Gout;
  logic [1:0]      FN;
  logic            DONE;
  logic            ERR;
  logic [CNTW-1:0] ICNT;

  modport master (
    output EXEC, INSTR, T,
    input  CLR, IRin, Rin, Rout, ENW, Ain, Gin, Gout, FN, DONE, ERR, ICNT
  );

  modport slave (
    input  EXEC, INSTR, T,
    output CLR, IRin, Rin, Rout, ENW, Ain, Gin, Gout, FN, DONE, ERR, ICNT
  );
endinterface

// File: rtl/timestep_controller.sv
// Instruction sequencer for the 10-bit processor: latches the instruction at T0,
// decodes per-timestep datapath enables, and restarts the timestep counter via CLR.
module timestep_controller #(
  parameter int NREG = 4,
  parameter int CNTW = 8
) (
  input logic                   CLKb,
  input logic                   CLRb,
  timestep_controller_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [9:0]      ir_q, ir_d;
  logic            clr_q, clr_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] icnt_q, icnt_d;

  logic [3:0]      op;
  logic [1:0]      rx, ry;
  logic            legal;
  logic            ir_unused;

  logic            irin, enw, ain, gin, gout, done;
  logic [NREG-1:0] rin, rout;
  logic [1:0]      fn;

  assign op        = ir_q[9:6];
  assign rx        = ir_q[5:4];
  assign ry        = ir_q[3:2];
  assign legal     = (op <= 4'd5);
  assign ir_unused = ^ir_q[1:0];

  // Decode is gated by RUN, so every enable is 0 while idle regardless of T.
  always_comb begin
    irin = 1'b0;
    enw  = 1'b0;
    ain  = 1'b0;
    gin  = 1'b0;
    gout = 1'b0;
    done = 1'b0;
    rin  = '0;
    rout = '0;
    fn   = '0;
    if (state_q == RUN) begin
      if (bus.T == 2'd0) begin
        irin = 1'b1;
      end else begin
        unique case (op)
          4'h0: if (bus.T == 2'd1) begin
            enw     = 1'b1;
            rin[rx] = 1'b1;
            done    = 1'b1;
          end
          4'h1: if (bus.T == 2'd1) begin
            rout[ry] = 1'b1;
            rin[rx]  = 1'b1;
            done     = 1'b1;
          end
          4'h2, 4'h3, 4'h4, 4'h5: begin
            unique case (bus.T)
              2'd1: begin
                rout[rx] = 1'b1;
                ain      = 1'b1;
              end
              2'd2: begin
                rout[ry] = 1'b1;
                gin      = 1'b1;
                fn       = 2'(op - 4'd2);
              end
              2'd3: begin
                gout    = 1'b1;
                rin[rx] = 1'b1;
                done    = 1'b1;
              end
              default: ;
            endcase
          end
          default: if (bus.T == 2'd1) done = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    clr_d   = clr_q;
    err_d   = err_q;
    icnt_d  = icnt_q;
    unique case (state_q)
      IDLE: begin
        clr_d = 1'b1;
        if (bus.EXEC) begin
          state_d = RUN;
          clr_d   = 1'b0;
        end
      end
      RUN: begin
        if (bus.T == 2'd0) ir_d = bus.INSTR;
        if (done) begin
          state_d = IDLE;
          clr_d   = 1'b1;
          if (legal) icnt_d = icnt_q + 1'b1;
          else       err_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge CLKb or negedge CLRb) begin
    if (!CLRb) begin
      state_q <= IDLE;
      ir_q    <= '0;
      clr_q   <= 1'b1;
      err_q   <= 1'b0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      clr_q   <= clr_d;
      err_q   <= err_d;
      icnt_q  <= icnt_d;
    end
  end

  assign bus.CLR  = clr_q;
  assign bus.ERR  = err_q;
  assign bus.ICNT = icnt_q;
  assign bus.IRin = irin;
  assign bus.Rin  = rin;
  assign bus.Rout = rout;
  assign bus.ENW  = enw;
  assign bus.Ain  = ain;
  assign bus.Gin  = gin;
  assign bus.Gout = gout;
  assign bus.FN   = fn;
  assign bus.DONE = done;

endmodule
